vga_pixel_gen: RTL and testbench
================================

Name: vga_pixel_gen

Overview:
- Pixel-generation stage directly downstream of the VGA sync block (640x480, 25 MHz pixel rate derived as a 1-in-4 enable from the 100 MHz board clock).
- Consumes pixel_x, pixel_y, video_on, hsync and vsync from the sync block. Renders a bouncing square over a bordered background.
- Outputs 12-bit RGB plus re-registered syncs, so colour and sync stay aligned at the connector.
- Square position updates once per frame, during vertical blanking.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BOX_SIZE, 32, square edge length in pixels
- SPEED, 2, pixels moved per frame on each axis
- BORDER, 8, width in pixels of the frame border
- BOX_X0, 304, reset x of square's top-left corner
- BOX_Y0, 224, reset y of square's top-left corner
- BOX_COLOR, 12'hF00, square colour
- BORDER_COLOR, 12'h0F0, border colour

Ports:
- clk, input, 1, 100 MHz board clock
- rst, input, 1, asynchronous active-high reset
- tick, input, 1, 25 MHz pixel enable from the sync block; one clk wide
- video_on, input, 1, high inside the 640x480 active area
- hsync_in, input, 1, active-low horizontal sync from the sync block
- vsync_in, input, 1, active-low vertical sync from the sync block
- pixel_x, input, 10, current horizontal pixel, 0..799
- pixel_y, input, 10, current vertical line, 0..524
- bg_color, input, 12, background colour; sampled each tick
- pause, input, 1, high freezes square motion
- rgb, output, 12, {R[3:0],G[3:0],B[3:0]} to DAC/pins
- hsync, output, 1, registered active-low hsync
- vsync, output, 1, registered active-low vsync

Behaviour:
- Clock and reset: reset is rst, asynchronous, active-high; clock is clk. All state is updated only on clk edges where tick=1, except asynchronous reset.
- Reset values: rgb=0, hsync=1, vsync=1, box_x=BOX_X0, box_y=BOX_Y0, dir_x=right, dir_y=down.
- Reset mid-frame: all state returns to its reset values immediately. Operation resumes with the next tick after rst deasserts; no resync to frame start is required.
- Latency: exactly one tick.
  - On a tick edge, rgb, hsync and vsync load the values computed from the inputs present at that edge.
  - hsync = hsync_in and vsync = vsync_in, delayed by the same one tick.
- Colour priority, evaluated on the inputs at the tick:
  - video_on=0 -> 12'h000.
  - Else inside square, i.e. box_x <= pixel_x < box_x+BOX_SIZE and box_y <= pixel_y < box_y+BOX_SIZE -> BOX_COLOR.
  - Else in border, i.e. pixel_x < BORDER, pixel_x >= H_ACTIVE-BORDER, pixel_y < BORDER or pixel_y >= V_ACTIVE-BORDER -> BORDER_COLOR.
  - Else -> bg_color.
- Comparisons use 11-bit unsigned arithmetic so that box_x+BOX_SIZE never wraps.
- Frame refresh strobe: refresh = tick & pixel_x==0 & pixel_y==V_ACTIVE+1 (line 481). It fires exactly once per frame, entirely in vertical blanking.
- Motion: on refresh with pause=0, each axis is updated independently. The x axis works as follows; y is identical with V_ACTIVE, box_y, dir_y and down/up.
  - dir_x=right:
    - If box_x > H_ACTIVE-BOX_SIZE-SPEED: box_x <= H_ACTIVE-BOX_SIZE and dir_x <= left.
    - Else: box_x <= box_x+SPEED.
  - dir_x=left:
    - If box_x < SPEED: box_x <= 0 and dir_x <= right.
    - Else: box_x <= box_x-SPEED.
  - When a flip occurs, the position is clamped and does not advance that frame.
- pause=1 at refresh: position and direction are held. Rendering continues.
- Position never changes during the active area, so there is no tearing.
- Simultaneous x and y bounces in the same refresh: both axes flip independently.

Test Plan:
- Reset check: assert rst mid-line, then release -> rgb=000, hsync=vsync=1 while rst is high. After release, the first refresh moves the square to (306,226).
- Render at reset position: drive pixel (310,230) with video_on=1 on a tick -> rgb=F00 at the next tick edge. For pixel (4,100): rgb=0F0. For pixel (100,100) with bg_color=00F: rgb=00F. With video_on=0: rgb=000.
- Sync alignment: hsync_in falls at pixel_x=656 -> hsync falls exactly one tick later. Non-tick clk edges leave every output unchanged.
- Right wall bounce, default parameters: refresh count 151 -> box_x=606; 152 -> 608; 153 -> 608 with dir_x=left; 154 -> 606.
- Bottom wall bounce: refresh count 112 -> box_y=448 with box_x=528; 113 -> box_y=448 with dir_y=up; 114 -> box_y=446.
- Pause: pause=1 across 10 refreshes -> box_x and box_y unchanged. After pause=0, the next refresh moves the square by exactly SPEED on each axis in its held direction.

Source files
------------

// File: rtl/vga_pixel_gen.sv
// Purpose: renders a bouncing square over a bordered background for 640x480 VGA, re-registering the syncs.
// Latency: one pixel tick from pixel_x/pixel_y/video_on/syncs to rgb/hsync/vsync.
// Backpressure: none; all state advances only on clk edges with tick=1, and the stage never stalls.
module vga_pixel_gen #(
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          BOX_SIZE     = 32,
    parameter int          SPEED        = 2,
    parameter int          BORDER       = 8,
    parameter int          BOX_X0       = 304,
    parameter int          BOX_Y0       = 224,
    parameter logic [11:0] BOX_COLOR    = 12'hF00,
    parameter logic [11:0] BORDER_COLOR = 12'h0F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [11:0] bg_color,
    input  logic        pause,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync
);

    // 11-bit copies of the geometry so box edge + size can never wrap
    localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
    localparam logic [10:0] BOX_W    = 11'(BOX_SIZE);
    localparam logic [10:0] BORDER_W = 11'(BORDER);

    // Motion limits: turn points and clamp positions on each axis
    localparam logic [9:0] X_MAX  = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0] X_TURN = 10'(H_ACTIVE - BOX_SIZE - SPEED);
    localparam logic [9:0] Y_MAX  = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [9:0] Y_TURN = 10'(V_ACTIVE - BOX_SIZE - SPEED);
    localparam logic [9:0] SPD    = 10'(SPEED);
    localparam logic [9:0] REFRESH_LINE = 10'(V_ACTIVE + 1);

    // Square position (top-left corner) and direction: dir_x 1=right, dir_y 1=down
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic       dir_x;
    logic       dir_y;

    logic [9:0] box_x_nxt;
    logic [9:0] box_y_nxt;
    logic       dir_x_nxt;
    logic       dir_y_nxt;

    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] bx;
    logic [10:0] by;
    logic        in_box;
    logic        in_border;
    logic        refresh;
    logic [11:0] pix_color;

    assign px = {1'b0, pixel_x};
    assign py = {1'b0, pixel_y};
    assign bx = {1'b0, box_x};
    assign by = {1'b0, box_y};

    // Line 481 pixel 0 is deep in vertical blanking, so moving here cannot tear the image
    assign refresh = tick && (pixel_x == 10'd0) && (pixel_y == REFRESH_LINE);

    assign in_box = (px >= bx) && (px < bx + BOX_W) &&
                    (py >= by) && (py < by + BOX_W);

    assign in_border = (px < BORDER_W) || (px >= H_ACT_W - BORDER_W) ||
                       (py < BORDER_W) || (py >= V_ACT_W - BORDER_W);

    // Colour priority: blanking, then square, then border, then background
    always_comb begin
        pix_color = bg_color;
        if (!video_on) begin
            pix_color = 12'h000;
        end else if (in_box) begin
            pix_color = BOX_COLOR;
        end else if (in_border) begin
            pix_color = BORDER_COLOR;
        end
    end

    // Next x position: advance, or clamp to the wall and reverse without advancing
    always_comb begin
        box_x_nxt = box_x;
        dir_x_nxt = dir_x;
        if (dir_x) begin
            if (box_x > X_TURN) begin
                box_x_nxt = X_MAX;
                dir_x_nxt = 1'b0;
            end else begin
                box_x_nxt = box_x + SPD;
            end
        end else begin
            if (box_x < SPD) begin
                box_x_nxt = 10'd0;
                dir_x_nxt = 1'b1;
            end else begin
                box_x_nxt = box_x - SPD;
            end
        end
    end

    // Next y position: same scheme as x, with down/up instead of right/left
    always_comb begin
        box_y_nxt = box_y;
        dir_y_nxt = dir_y;
        if (dir_y) begin
            if (box_y > Y_TURN) begin
                box_y_nxt = Y_MAX;
                dir_y_nxt = 1'b0;
            end else begin
                box_y_nxt = box_y + SPD;
            end
        end else begin
            if (box_y < SPD) begin
                box_y_nxt = 10'd0;
                dir_y_nxt = 1'b1;
            end else begin
                box_y_nxt = box_y - SPD;
            end
        end
    end

    // Output registers: colour and syncs share one tick of delay so they stay aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb   <= 12'h000;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (tick) begin
            rgb   <= pix_color;
            hsync <= hsync_in;
            vsync <= vsync_in;
        end
    end

    // Square motion: once per frame at the refresh strobe, held while paused
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            box_x <= 10'(BOX_X0);
            box_y <= 10'(BOX_Y0);
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (refresh && !pause) begin
            box_x <= box_x_nxt;
            box_y <= box_y_nxt;
            dir_x <= dir_x_nxt;
            dir_y <= dir_y_nxt;
        end
    end

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Directed bench for vga_pixel_gen: reset, rendering priority, sync alignment, wall bounces and pause.
module tb_vga_pixel_gen;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [11:0] bg_color;
    logic        pause;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;

    int passed;
    int total;

    vga_pixel_gen dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .video_on (video_on),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .bg_color (bg_color),
        .pause    (pause),
        .rgb      (rgb),
        .hsync    (hsync),
        .vsync    (vsync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clk edge with tick=1 carrying the given inputs; returns at the following negedge
    task automatic drive_tick(input logic [9:0] x, input logic [9:0] y, input logic von,
                              input logic hs, input logic vs);
        @(negedge clk);
        pixel_x  = x;
        pixel_y  = y;
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        tick     = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_refresh();
        drive_tick(10'd0, 10'd481, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (rgb !== 12'h000 || hsync !== 1'b1 || vsync !== 1'b1) begin
            $display("FAIL reset_outputs: rgb=%h hs=%b vs=%b, required 000 1 1", rgb, hsync, vsync);
        end else passed++;
        total++;
        if (dut.box_x !== 10'd304 || dut.box_y !== 10'd224 || dut.dir_x !== 1'b1 || dut.dir_y !== 1'b1) begin
            $display("FAIL reset_state: box=(%0d,%0d) dir=%b%b, required (304,224) 11",
                     dut.box_x, dut.box_y, dut.dir_x, dut.dir_y);
        end else passed++;
        rst = 1'b0;
        do_refresh();
        drive_tick(10'd310, 10'd230, 1'b1, 1'b0, 1'b0);
        total++;
        if (rgb !== 12'hF00 || hsync !== 1'b0 || vsync !== 1'b0) begin
            $display("FAIL pre_midline_reset: rgb=%h hs=%b vs=%b, required f00 0 0", rgb, hsync, vsync);
        end else passed++;
        // Assert reset mid-line, between clock edges: outputs must clear at once
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (rgb !== 12'h000 || hsync !== 1'b1 || vsync !== 1'b1) begin
            $display("FAIL async_reset_outputs: rgb=%h hs=%b vs=%b, required 000 1 1", rgb, hsync, vsync);
        end else passed++;
        total++;
        if (dut.box_x !== 10'd304 || dut.box_y !== 10'd224) begin
            $display("FAIL async_reset_box: box=(%0d,%0d), required (304,224)", dut.box_x, dut.box_y);
        end else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_refresh();
        total++;
        if (dut.box_x !== 10'd306 || dut.box_y !== 10'd226) begin
            $display("FAIL first_refresh: box=(%0d,%0d), required (306,226)", dut.box_x, dut.box_y);
        end else passed++;
    endtask

    task automatic test_render();
        logic [9:0]  xs   [10];
        logic [9:0]  ys   [10];
        logic        vo   [10];
        logic [11:0] want [10];
        do_reset();
        bg_color = 12'h00F;
        // Square spans x 304..335, y 224..255; border 8 px; active 640x480
        xs[0] = 10'd310; ys[0] = 10'd230; vo[0] = 1'b1; want[0] = 12'hF00;
        xs[1] = 10'd4;   ys[1] = 10'd100; vo[1] = 1'b1; want[1] = 12'h0F0;
        xs[2] = 10'd100; ys[2] = 10'd100; vo[2] = 1'b1; want[2] = 12'h00F;
        xs[3] = 10'd310; ys[3] = 10'd230; vo[3] = 1'b0; want[3] = 12'h000;
        xs[4] = 10'd335; ys[4] = 10'd255; vo[4] = 1'b1; want[4] = 12'hF00;
        xs[5] = 10'd336; ys[5] = 10'd230; vo[5] = 1'b1; want[5] = 12'h00F;
        xs[6] = 10'd303; ys[6] = 10'd256; vo[6] = 1'b1; want[6] = 12'h00F;
        xs[7] = 10'd632; ys[7] = 10'd100; vo[7] = 1'b1; want[7] = 12'h0F0;
        xs[8] = 10'd631; ys[8] = 10'd8;   vo[8] = 1'b1; want[8] = 12'h00F;
        xs[9] = 10'd100; ys[9] = 10'd472; vo[9] = 1'b1; want[9] = 12'h0F0;
        for (int i = 0; i < 10; i++) begin
            drive_tick(xs[i], ys[i], vo[i], 1'b1, 1'b1);
            total++;
            if (rgb !== want[i]) begin
                $display("FAIL render_%0d (%0d,%0d,von=%b): rgb=%h, required %h",
                         i, xs[i], ys[i], vo[i], rgb, want[i]);
            end else passed++;
        end
    endtask

    task automatic test_sync();
        drive_tick(10'd655, 10'd100, 1'b0, 1'b1, 1'b1);
        total++;
        if (hsync !== 1'b1) begin
            $display("FAIL hsync_before_fall: hsync=%b, required 1", hsync);
        end else passed++;
        drive_tick(10'd656, 10'd100, 1'b0, 1'b0, 1'b0);
        total++;
        if (hsync !== 1'b0 || vsync !== 1'b0) begin
            $display("FAIL sync_fall_one_tick: hs=%b vs=%b, required 0 0", hsync, vsync);
        end else passed++;
        // Change every input but hold tick low: outputs must not move
        pixel_x  = 10'd310;
        pixel_y  = 10'd230;
        video_on = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (rgb !== 12'h000 || hsync !== 1'b0 || vsync !== 1'b0) begin
                $display("FAIL non_tick_hold_%0d: rgb=%h hs=%b vs=%b, required 000 0 0",
                         i, rgb, hsync, vsync);
            end else passed++;
        end
        drive_tick(10'd310, 10'd230, 1'b1, 1'b1, 1'b1);
        total++;
        if (rgb !== 12'hF00 || hsync !== 1'b1 || vsync !== 1'b1) begin
            $display("FAIL tick_after_hold: rgb=%h hs=%b vs=%b, required f00 1 1", rgb, hsync, vsync);
        end else passed++;
    endtask

    task automatic test_bounce();
        do_reset();
        for (int n = 1; n <= 154; n++) begin
            do_refresh();
            if (n == 112) begin
                total++;
                if (dut.box_y !== 10'd448 || dut.box_x !== 10'd528 || dut.dir_y !== 1'b1) begin
                    $display("FAIL bottom_112: box=(%0d,%0d) dir_y=%b, required (528,448) 1",
                             dut.box_x, dut.box_y, dut.dir_y);
                end else passed++;
            end
            if (n == 113) begin
                total++;
                if (dut.box_y !== 10'd448 || dut.dir_y !== 1'b0) begin
                    $display("FAIL bottom_113: box_y=%0d dir_y=%b, required 448 0", dut.box_y, dut.dir_y);
                end else passed++;
            end
            if (n == 114) begin
                total++;
                if (dut.box_y !== 10'd446 || dut.dir_y !== 1'b0) begin
                    $display("FAIL bottom_114: box_y=%0d dir_y=%b, required 446 0", dut.box_y, dut.dir_y);
                end else passed++;
            end
            if (n == 151) begin
                total++;
                if (dut.box_x !== 10'd606 || dut.dir_x !== 1'b1) begin
                    $display("FAIL right_151: box_x=%0d dir_x=%b, required 606 1", dut.box_x, dut.dir_x);
                end else passed++;
            end
            if (n == 152) begin
                total++;
                if (dut.box_x !== 10'd608 || dut.dir_x !== 1'b1) begin
                    $display("FAIL right_152: box_x=%0d dir_x=%b, required 608 1", dut.box_x, dut.dir_x);
                end else passed++;
            end
            if (n == 153) begin
                total++;
                if (dut.box_x !== 10'd608 || dut.dir_x !== 1'b0 || dut.box_y !== 10'd368) begin
                    $display("FAIL right_153: box=(%0d,%0d) dir_x=%b, required (608,368) 0",
                             dut.box_x, dut.box_y, dut.dir_x);
                end else passed++;
                // Square at 608..639 x 368..399 overlaps the right border and wins
                drive_tick(10'd639, 10'd380, 1'b1, 1'b1, 1'b1);
                total++;
                if (rgb !== 12'hF00) begin
                    $display("FAIL box_over_border: rgb=%h, required f00", rgb);
                end else passed++;
                drive_tick(10'd607, 10'd380, 1'b1, 1'b1, 1'b1);
                total++;
                if (rgb !== 12'h00F) begin
                    $display("FAIL left_of_box: rgb=%h, required 00f", rgb);
                end else passed++;
            end
            if (n == 154) begin
                total++;
                if (dut.box_x !== 10'd606 || dut.dir_x !== 1'b0) begin
                    $display("FAIL right_154: box_x=%0d dir_x=%b, required 606 0", dut.box_x, dut.dir_x);
                end else passed++;
            end
        end
    endtask

    task automatic test_pause();
        // Entering from bounce: box at (606,366), moving left and up
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            do_refresh();
        end
        total++;
        if (dut.box_x !== 10'd606 || dut.box_y !== 10'd366 || dut.dir_x !== 1'b0 || dut.dir_y !== 1'b0) begin
            $display("FAIL pause_hold: box=(%0d,%0d) dir=%b%b, required (606,366) 00",
                     dut.box_x, dut.box_y, dut.dir_x, dut.dir_y);
        end else passed++;
        drive_tick(10'd610, 10'd370, 1'b1, 1'b1, 1'b1);
        total++;
        if (rgb !== 12'hF00) begin
            $display("FAIL pause_render: rgb=%h, required f00", rgb);
        end else passed++;
        pause = 1'b0;
        do_refresh();
        total++;
        if (dut.box_x !== 10'd604 || dut.box_y !== 10'd364) begin
            $display("FAIL pause_resume: box=(%0d,%0d), required (604,364)", dut.box_x, dut.box_y);
        end else passed++;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        rst      = 1'b1;
        tick     = 1'b0;
        video_on = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        pixel_x  = 10'd0;
        pixel_y  = 10'd0;
        bg_color = 12'h00F;
        pause    = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_render();
        test_sync();
        test_bounce();
        test_pause();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
